cordic_host_port: RTL and testbench

Host-side driver for the CORDIC control block's shared 13-bit sample/result bus. It accepts one I/Q sample pair per transaction on a valid/ready stream and serialises I then Q onto the bus with `Enable`/`IN_N_OUT`. It then waits for `Data_Ready`, captures the PM and AM words that follow, and presents them as a buffered result. It sits between the sample source and the CORDIC control block, on the other end of that block's bus protocol.

---
 rtl/cordic_host_port_if.sv | 34 +++
 rtl/cordic_host_port.sv | 103 ++++++++++
 tb/tb_cordic_host_port.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_host_port_if.sv
// Host-side bundle between the sample source, the CORDIC control block bus and the result sink.
// Both streams use valid/ready: a word transfers on a rising edge where valid && ready; valid never waits on ready.
interface cordic_host_port_if #(
  parameter int W = 13
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_i;
  logic [W-1:0] s_q;

  logic         Enable;
  logic         IN_N_OUT;
  logic [W-1:0] Bus_Data;
  logic [W-1:0] Data_out;
  logic         Data_Ready;

  logic         r_valid;
  logic         r_ready;
  logic [W-1:0] r_pm;
  logic [W-1:0] r_am;

  logic         Timeout_Err;
  logic         Busy;

  modport slave (
    input  s_valid, s_i, s_q, Data_out, Data_Ready, r_ready,
    output s_ready, Enable, IN_N_OUT, Bus_Data, r_valid, r_pm, r_am, Timeout_Err, Busy
  );

  modport master (
    output s_valid, s_i, s_q, Data_out, Data_Ready, r_ready,
    input  s_ready, Enable, IN_N_OUT, Bus_Data, r_valid, r_pm, r_am, Timeout_Err, Busy
  );
endinterface

// File: rtl/cordic_host_port.sv
// Serialises one I/Q pair onto the shared CORDIC bus, waits for Data_Ready, then captures PM and AM
// into a single-entry result buffer. Unsolicited responses arriving while idle are drained and dropped.
module cordic_host_port #(
  parameter int W       = 13,
  parameter int TIMEOUT = 1000
) (
  input  logic                CLK1,
  input  logic                RST_n,
  cordic_host_port_if.slave   host,
  output logic [2:0]          o_dbg_state
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_I, S_SEND_Q, S_WAIT, S_GET_PM, S_GET_AM, S_DRAIN_PM, S_DRAIN_AM
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_i;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_pm;
  logic [W-1:0]   r_am;
  logic           r_valid;
  logic           r_tmo;
  logic           w_s_ready;
  logic           w_accept;
  logic           w_consume;
  logic           w_expire;

  // A pending Data_Ready in IDLE must be drained first, so it also blocks a launch.
  assign w_s_ready = RST_n && (r_state == S_IDLE) && !host.Data_Ready && (!r_valid || host.r_ready);
  assign w_accept  = host.s_valid && w_s_ready;
  assign w_consume = r_valid && host.r_ready;
  assign w_expire  = (r_state == S_WAIT) && !host.Data_Ready && (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (host.Data_Ready)  w_next = S_DRAIN_PM;
        else if (w_accept)    w_next = S_SEND_I;
      end
      S_SEND_I:   w_next = S_SEND_Q;
      S_SEND_Q:   w_next = S_WAIT;
      S_WAIT: begin
        if (host.Data_Ready)  w_next = S_GET_PM;
        else if (w_expire)    w_next = S_IDLE;
      end
      S_GET_PM:   w_next = S_GET_AM;
      S_GET_AM:   w_next = S_IDLE;
      S_DRAIN_PM: w_next = S_DRAIN_AM;
      S_DRAIN_AM: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_i     <= '0;
      r_q     <= '0;
      r_pm    <= '0;
      r_am    <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= w_expire;
      if (w_accept) begin
        r_i <= host.s_i;
        r_q <= host.s_q;
      end
      if (r_state == S_SEND_Q)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) && !host.Data_Ready)
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_GET_PM)
        r_pm <= host.Data_out;
      // Set beats clear: a launch is impossible while a result is unconsumed.
      if (r_state == S_GET_AM) begin
        r_am    <= host.Data_out;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign host.s_ready     = w_s_ready;
  assign host.Enable      = (r_state == S_SEND_I);
  assign host.IN_N_OUT    = !((r_state == S_SEND_I) || (r_state == S_SEND_Q));
  assign host.Bus_Data    = (r_state == S_SEND_I) ? r_i :
                            (r_state == S_SEND_Q) ? r_q : '0;
  assign host.r_valid     = r_valid;
  assign host.r_pm        = r_pm;
  assign host.r_am        = r_am;
  assign host.Timeout_Err = r_tmo;
  assign host.Busy        = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_cordic_host_port.sv
// Bench for cordic_host_port: a behavioural control-block responder, a result scoreboard,
// directed table vectors, back-to-back, backpressure, timeout/drain, mid-WAIT reset and random traffic.
module tb_cordic_host_port;
  localparam int W   = 13;
  localparam int TMO = 20;

  typedef struct {
    logic [W-1:0] i;
    logic [W-1:0] q;
    logic [W-1:0] pm;
    logic [W-1:0] am;
    int           dly;  // cycles after WAIT entry until Data_Ready is sampled; 0 = never respond
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  cordic_host_port_if #(.W(W)) bus ();

  cordic_host_port #(.W(W), .TIMEOUT(TMO)) dut (
    .CLK1        (clk),
    .RST_n       (rst_n),
    .host        (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_iq[$];
  logic [2*W-1:0] exp_q[$];
  vec_t           plan_q[$];
  logic [W-1:0]   last_pm = '0;
  logic [W-1:0]   last_am = '0;
  bit             resp_busy = 0;
  bit             expect_b2b = 0;
  bit             rand_rr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enable"},   bus.Enable, 0);
    chk({tag, "_in_n_out"}, bus.IN_N_OUT, 1);
    chk({tag, "_bus_data"}, bus.Bus_Data, 0);
    chk({tag, "_r_valid"},  bus.r_valid, 0);
    chk({tag, "_r_pm"},     bus.r_pm, 0);
    chk({tag, "_r_am"},     bus.r_am, 0);
    chk({tag, "_timeout"},  bus.Timeout_Err, 0);
    chk({tag, "_busy"},     bus.Busy, 0);
    chk({tag, "_s_ready"},  bus.s_ready, 0);
  endtask

  function automatic vec_t rand_vec(input int lo, input int hi);
    vec_t r;
    r.i   = W'($urandom);
    r.q   = W'($urandom);
    r.pm  = W'($urandom);
    r.am  = W'($urandom);
    r.dly = int'($urandom_range(hi, lo));
    return r;
  endfunction

  task automatic send_pair(input vec_t v, output int waited);
    plan_q.push_back(v);
    exp_iq.push_back({v.i, v.q});
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_i     = v.i;
    bus.s_q     = v.q;
    waited      = 0;
    #4;
    while (!bus.s_ready && waited < 200) begin
      @(negedge clk);
      #4;
      waited++;
    end
    chk("accept_wait", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_i     = W'($urandom);
    bus.s_q     = W'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_iq.size() != 0 || resp_busy || bus.Busy || bus.r_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (n < 400), 1);
  endtask

  // Control-block model: takes I then Q off the bus, answers after the planned delay.
  initial begin : responder
    vec_t v;
    logic [W-1:0] gi, gq;
    logic [2*W-1:0] e;
    bit b2b_arm, tmo_seen, tmo_bad, late;
    b2b_arm = 0;
    forever begin
      @(negedge clk);
      if (b2b_arm) begin
        chk("b2b_enable", bus.Enable, 1);
        b2b_arm = 0;
      end
      if (rst_n && bus.Enable) begin
        resp_busy = 1;
        gi = bus.Bus_Data;
        chk("send_i_dir", bus.IN_N_OUT, 0);
        @(negedge clk);
        gq = bus.Bus_Data;
        chk("send_q_strobe", {bus.Enable, bus.IN_N_OUT}, 2'b00);
        chk("launch_planned", (plan_q.size() > 0 && exp_iq.size() > 0), 1);
        if (plan_q.size() > 0 && exp_iq.size() > 0) begin
          v = plan_q.pop_front();
          e = exp_iq.pop_front();
          chk("bus_words", {gi, gq}, e);
          if (v.dly > 0) begin
            late     = (v.dly > TMO);
            tmo_seen = 0;
            tmo_bad  = 0;
            for (int k = 1; k <= v.dly; k++) begin
              @(negedge clk);
              if (k == 1) chk("wait_bus_idle", {bus.Enable, bus.IN_N_OUT, bus.Bus_Data}, {2'b01, {W{1'b0}}});
              if (bus.Timeout_Err) begin
                if (k == TMO + 1) tmo_seen = 1;
                else tmo_bad = 1;
              end
              if (late && k == TMO + 1) chk("timeout_idle", {bus.Busy, bus.r_valid}, 2'b00);
            end
            chk("timeout_pulse", {tmo_seen, tmo_bad}, late ? 2'b10 : 2'b00);
            if (!late) exp_q.push_back({v.pm, v.am});
            bus.Data_Ready = 1'b1;
            @(negedge clk);
            bus.Data_Ready = 1'b0;
            bus.Data_out   = v.pm;
            chk("tmo_one_cycle", bus.Timeout_Err, 0);
            @(negedge clk);
            bus.Data_out = v.am;
            @(negedge clk);
            bus.Data_out = W'($urandom);
            if (late) begin
              chk("drain_keeps_result", {bus.r_valid, bus.r_pm, bus.r_am}, {1'b0, last_pm, last_am});
            end else begin
              chk("rvalid_at_ed2", {bus.r_valid, bus.r_pm, bus.r_am}, {1'b1, v.pm, v.am});
              if (expect_b2b && exp_iq.size() > 0) b2b_arm = 1;
            end
          end
        end
        resp_busy = 0;
      end
    end
  end

  initial begin : consumer
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.r_valid && bus.r_ready) begin
        chk("result_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", {bus.r_pm, bus.r_am}, e);
          last_pm = e[2*W-1:W];
          last_am = e[W-1:0];
        end
      end
    end
  end

  initial begin : rr_randomiser
    forever begin
      @(negedge clk);
      if (rand_rr) bus.r_ready = ($urandom_range(3, 0) != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t dir_tbl[4];
    vec_t v;
    int   waited, n;
    bit   bad;

    bus.s_valid    = 1'b0;
    bus.s_i        = '0;
    bus.s_q        = '0;
    bus.Data_out   = '0;
    bus.Data_Ready = 1'b0;
    bus.r_ready    = 1'b1;

    dir_tbl[0] = '{13'h0100, 13'h0080, 13'h0123, 13'h0456, 10};
    dir_tbl[1] = '{13'h1FFF, 13'h0000, 13'h1FFF, 13'h0001, 1};
    dir_tbl[2] = '{13'h0ABC, 13'h1234, 13'h0F0F, 13'h10F0, TMO};
    dir_tbl[3] = '{13'h0001, 13'h1FFE, 13'h0555, 13'h1AAA, TMO - 1};

    // Reset with a sample already offered: nothing may be accepted.
    rst_n       = 1'b0;
    bus.s_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n       = 1'b1;

    foreach (dir_tbl[i]) begin
      send_pair(dir_tbl[i], waited);
      chk("dir_accept_latency", waited, 0);
      wait_drain();
    end

    expect_b2b = 1;
    for (int i = 0; i < 4; i++) begin
      v = rand_vec(1, 12);
      send_pair(v, waited);
    end
    wait_drain();
    expect_b2b = 0;

    // Backpressure: the held result blocks the next launch until r_ready rises.
    bus.r_ready = 1'b0;
    v = rand_vec(1, 8);
    send_pair(v, waited);
    n = 0;
    while (!bus.r_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_result_ready", bus.r_valid, 1);
    v = rand_vec(1, 8);
    plan_q.push_back(v);
    exp_iq.push_back({v.i, v.q});
    bus.s_valid = 1'b1;
    bus.s_i     = v.i;
    bus.s_q     = v.q;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      #4;
      if (bus.s_ready || bus.Enable) bad = 1;
    end
    chk("bp_hold", bad, 0);
    @(negedge clk);
    bus.r_ready = 1'b1;
    #4;
    chk("bp_same_edge", {bus.s_ready, bus.r_valid}, 2'b11);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("bp_after", {bus.r_valid, bus.Enable}, 2'b01);
    wait_drain();

    // Timeout, then the late answer is drained while the next pair waits.
    v = '{13'h0111, 13'h0222, 13'h0AAA, 13'h0BBB, TMO + 1};
    send_pair(v, waited);
    v = rand_vec(1, 8);
    send_pair(v, waited);
    chk("late_drain_holdoff", waited, TMO + 5);
    chk("late_keeps_result", {bus.r_valid, bus.r_pm, bus.r_am}, {1'b0, last_pm, last_am});
    wait_drain();

    // Reset in the middle of WAIT.
    v     = rand_vec(1, 1);
    v.dly = 0;
    send_pair(v, waited);
    repeat (5) @(negedge clk);
    chk("midwait_busy", bus.Busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait");
    repeat (3) @(negedge clk);
    chk_reset_outputs("held");
    rst_n   = 1'b1;
    last_pm = '0;
    last_am = '0;
    v = rand_vec(1, 10);
    send_pair(v, waited);
    chk("post_reset_accept", waited, 0);
    wait_drain();

    rand_rr = 1;
    for (int i = 0; i < 20; i++) begin
      v = rand_vec(1, TMO + 1);
      send_pair(v, waited);
    end
    rand_rr = 0;
    @(negedge clk);
    bus.r_ready = 1'b1;
    wait_drain();
    chk("queues_empty", exp_q.size() + plan_q.size() + exp_iq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
